// File: rtl/led_pulse_stretcher.sv
// led_pulse_stretcher
//   Turns 1-cycle event strobes into human-visible LED blinks. Each event
//   yields one ON_CYC-cycle lit phase followed by an OFF_CYC-cycle forced dark
//   gap, so back-to-back events remain distinguishable. Events that arrive
//   while a blink is in progress are queued in a saturating counter.
// Ports
//   clk       system clock
//   reset     synchronous, active-high
//   pulse_in  event strobe, one cycle per event
//   ovf_clr   clears the sticky overflow flag
//   led_out   registered LED drive, 1 = lit
//   busy      registered, 1 whenever the FSM is not IDLE
//   pending   registered count of queued blinks not yet started
//   overflow  registered sticky flag: an event was dropped at saturation
module led_pulse_stretcher #(
  parameter int CYCLES_PER_MS = 50_000,
  parameter int ON_TIME_MS    = 100,
  parameter int OFF_TIME_MS   = 100,
  parameter int PEND_BITS     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pulse_in,
  input  logic                 ovf_clr,
  output logic                 led_out,
  output logic                 busy,
  output logic [PEND_BITS-1:0] pending,
  output logic                 overflow
);

  localparam int ON_CYC  = ON_TIME_MS * CYCLES_PER_MS;
  localparam int OFF_CYC = OFF_TIME_MS * CYCLES_PER_MS;
  localparam int MAX_CYC = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  // A single-cycle phase would give a zero-width timer; keep at least one bit.
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TW-1:0]        ON_LOAD  = TW'(ON_CYC - 1);
  localparam logic [TW-1:0]        OFF_LOAD = TW'(OFF_CYC - 1);
  localparam logic [PEND_BITS-1:0] PEND_MAX = '1;

  generate
    if (ON_TIME_MS < 1)  begin : g_bad_on
      $error("led_pulse_stretcher: ON_TIME_MS must be >= 1");
    end
    if (OFF_TIME_MS < 1) begin : g_bad_off
      $error("led_pulse_stretcher: OFF_TIME_MS must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic          pend_inc, pend_dec;
  logic          led_nx, busy_nx;

  // State register plus all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= '0;
      led_out  <= 1'b0;
      busy     <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      state   <= state_nx;
      timer   <= timer_nx;
      led_out <= led_nx;
      busy    <= busy_nx;

      // Simultaneous increment and decrement cancel out.
      case ({pend_inc, pend_dec})
        2'b10:   if (pending != PEND_MAX) pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: ;
      endcase

      // Set has priority over clear when both land in the same cycle.
      if (pend_inc && !pend_dec && pending == PEND_MAX) overflow <= 1'b1;
      else if (ovf_clr)                                  overflow <= 1'b0;
    end
  end

  // Next-state, timer and queue control.
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    pend_inc = 1'b0;
    pend_dec = 1'b0;
    case (state)
      IDLE: begin
        if (pulse_in) begin
          state_nx = ON;
          timer_nx = ON_LOAD;
        end
      end
      ON: begin
        pend_inc = pulse_in;
        if (timer == '0) begin
          state_nx = GAP;
          timer_nx = OFF_LOAD;
        end else begin
          timer_nx = timer - TW'(1);
        end
      end
      GAP: begin
        if (timer == '0) begin
          // Last dark cycle: a queued event takes precedence; otherwise a
          // fresh strobe is consumed directly without touching the queue.
          if (pending != '0) begin
            pend_dec = 1'b1;
            pend_inc = pulse_in;
            state_nx = ON;
            timer_nx = ON_LOAD;
          end else if (pulse_in) begin
            state_nx = ON;
            timer_nx = ON_LOAD;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          pend_inc = pulse_in;
          timer_nx = timer - TW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        timer_nx = '0;
      end
    endcase
  end

  // Output decode on the next state so the registered outputs line up with
  // the state they describe.
  always_comb begin
    led_nx  = (state_nx == ON);
    busy_nx = (state_nx != IDLE);
  end

endmodule

// File: tb/tb_led_pulse_stretcher.sv
module tb_led_pulse_stretcher;

  localparam int NCYC = 45;

  logic       clk = 1'b0;
  logic       reset, pulse_in, ovf_clr;
  logic       led_out, busy, overflow;
  logic [1:0] pending;

  led_pulse_stretcher #(
    .CYCLES_PER_MS(1), .ON_TIME_MS(3), .OFF_TIME_MS(2), .PEND_BITS(2)
  ) dut (
    .clk(clk), .reset(reset), .pulse_in(pulse_in), .ovf_clr(ovf_clr),
    .led_out(led_out), .busy(busy), .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       led;
    logic       busy;
    logic [1:0] pend;
    logic       ovf;
  } exp_t;

  exp_t sb[$];

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   tid = 0;
  logic active = 1'b0;

  logic s_pulse[NCYC];
  logic s_rst[NCYC];
  logic s_clr[NCYC];
  logic e_led[NCYC];
  logic e_busy[NCYC];
  int   e_pend[NCYC];
  logic e_ovf[NCYC];

  task automatic clear_tables();
    for (int k = 0; k < NCYC; k++) begin
      s_pulse[k] = 1'b0; s_rst[k] = (k < 2); s_clr[k] = 1'b0;
      e_led[k] = 1'b0; e_busy[k] = 1'b0; e_pend[k] = 0; e_ovf[k] = 1'b0;
    end
  endtask

  task automatic pulses(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) s_pulse[k] = 1'b1;
  endtask
  task automatic led_on(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) e_led[k] = 1'b1;
  endtask
  task automatic busy_on(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) e_busy[k] = 1'b1;
  endtask
  task automatic pend_set(input int lo, input int hi, input int v);
    for (int k = lo; k <= hi; k++) e_pend[k] = v;
  endtask
  task automatic ovf_on(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) e_ovf[k] = 1'b1;
  endtask

  // Issue one directed test: queue the hand-computed expectations, then
  // drive the stimulus cycle by cycle. Inputs change #1 after posedge.
  task automatic run_test(input int t);
    exp_t e;
    tid = t;
    for (int k = 2; k < NCYC; k++) begin
      e.cyc = k; e.led = e_led[k]; e.busy = e_busy[k];
      e.pend = 2'(e_pend[k]); e.ovf = e_ovf[k];
      sb.push_back(e);
    end
    active = 1'b1;
    for (int k = 0; k < NCYC; k++) begin
      cyc      = k;
      reset    = s_rst[k];
      pulse_in = s_pulse[k];
      ovf_clr  = s_clr[k];
      @(posedge clk); #1;
    end
    // Marker cycle: the monitor confirms every expectation was consumed.
    cyc = -1;
    reset = 1'b0; pulse_in = 1'b0; ovf_clr = 1'b0;
    @(posedge clk); #1;
    active = 1'b0;
  endtask

  // Monitor: samples on the falling edge and retires matching expectations.
  always @(negedge clk) begin
    if (active) begin
      if (cyc == -1) begin
        checks++;
        if (sb.size() != 0) begin
          failures++;
          $display("FAIL t%0d drain leftover=%0d required=0", tid, sb.size());
          sb.delete();
        end
      end else begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
          exp_t e;
          e = sb.pop_front();
          checks += 4;
          if (e.cyc != cyc) begin
            failures++;
            $display("FAIL t%0d missed expectation for c%0d at c%0d", tid, e.cyc, cyc);
          end
          if (led_out !== e.led) begin
            failures++;
            $display("FAIL t%0d c%0d led_out got=%0b exp=%0b", tid, cyc, led_out, e.led);
          end
          if (busy !== e.busy) begin
            failures++;
            $display("FAIL t%0d c%0d busy got=%0b exp=%0b", tid, cyc, busy, e.busy);
          end
          if (pending !== e.pend) begin
            failures++;
            $display("FAIL t%0d c%0d pending got=%0d exp=%0d", tid, cyc, pending, e.pend);
          end
          if (overflow !== e.ovf) begin
            failures++;
            $display("FAIL t%0d c%0d overflow got=%0b exp=%0b", tid, cyc, overflow, e.ovf);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; pulse_in = 1'b0; ovf_clr = 1'b0;

    // 1: reset only, everything quiet.
    clear_tables();
    run_test(1);

    // 2: single pulse.
    clear_tables();
    pulses(10, 10);
    led_on(11, 13); busy_on(11, 15);
    run_test(2);

    // 3: three pulses, two queued.
    clear_tables();
    pulses(10, 12);
    led_on(11, 13); led_on(16, 18); led_on(21, 23); busy_on(11, 25);
    pend_set(12, 12, 1); pend_set(13, 15, 2); pend_set(16, 20, 1);
    run_test(3);

    // 4: five pulses, queue saturates and one is dropped; clear at 40.
    clear_tables();
    pulses(10, 14); s_clr[40] = 1'b1;
    led_on(11, 13); led_on(16, 18); led_on(21, 23); led_on(26, 28); busy_on(11, 30);
    pend_set(12, 12, 1); pend_set(13, 13, 2); pend_set(14, 15, 3);
    pend_set(16, 20, 2); pend_set(21, 25, 1);
    ovf_on(15, 40);
    run_test(4);

    // 5: pulse on the last gap cycle with an empty queue is consumed directly.
    clear_tables();
    pulses(10, 10); pulses(15, 15);
    led_on(11, 13); led_on(16, 18); busy_on(11, 20);
    run_test(5);

    // 6: reset mid-blink, then a fresh pulse.
    clear_tables();
    pulses(10, 10); s_rst[12] = 1'b1; pulses(14, 14);
    led_on(11, 12); led_on(15, 17); busy_on(11, 12); busy_on(15, 19);
    run_test(6);

    // 7: simultaneous increment and decrement on the last gap cycle.
    clear_tables();
    pulses(10, 11); pulses(15, 15);
    led_on(11, 13); led_on(16, 18); led_on(21, 23); busy_on(11, 25);
    pend_set(12, 20, 1);
    run_test(7);

    // 8: overflow set and clear in the same cycle, set wins.
    clear_tables();
    pulses(10, 14); s_clr[14] = 1'b1; s_clr[40] = 1'b1;
    led_on(11, 13); led_on(16, 18); led_on(21, 23); led_on(26, 28); busy_on(11, 30);
    pend_set(12, 12, 1); pend_set(13, 13, 2); pend_set(14, 15, 3);
    pend_set(16, 20, 2); pend_set(21, 25, 1);
    ovf_on(15, 40);
    run_test(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
